// File: rtl/wb_stage_pkg.sv
// Shared writeback encodings: wb_sel values and load funct3 codes (also used by the decoder),
// plus the MEM/WB pipeline register layout.
package wb_stage_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [2:0] LOAD_F3_LB  = 3'b000;
  localparam logic [2:0] LOAD_F3_LH  = 3'b001;
  localparam logic [2:0] LOAD_F3_LW  = 3'b010;
  localparam logic [2:0] LOAD_F3_LBU = 3'b100;
  localparam logic [2:0] LOAD_F3_LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic        rd_wen;
    logic [4:0]  waddr;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [31:0] load_word;
  } mem_wb_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-side inputs and rf write-port outputs of the writeback stage.
// Handshake: no backpressure; i_valid qualifies the MEM-side fields, i_stall holds and i_flush squashes.
interface wb_stage_if #(parameter int RETIRE_CNT_W = 32);
  logic                    i_valid;
  logic                    i_stall;
  logic                    i_flush;
  logic                    i_rd_wen;
  logic [4:0]              i_rd_waddr;
  logic [1:0]              i_wb_sel;
  logic [2:0]              i_funct3;
  logic [1:0]              i_addr_lo;
  logic [31:0]             i_alu_result;
  logic [31:0]             i_pc_plus4;
  logic [31:0]             i_load_word;
  logic                    o_rd_wen;
  logic [4:0]              o_rd_waddr;
  logic [31:0]             o_rd_wdata;
  logic                    o_retire;
  logic                    o_misaligned;
  logic [RETIRE_CNT_W-1:0] o_retire_cnt;

  modport master (
    output i_valid, i_stall, i_flush, i_rd_wen, i_rd_waddr, i_wb_sel, i_funct3,
           i_addr_lo, i_alu_result, i_pc_plus4, i_load_word,
    input  o_rd_wen, o_rd_waddr, o_rd_wdata, o_retire, o_misaligned, o_retire_cnt
  );

  modport slave (
    input  i_valid, i_stall, i_flush, i_rd_wen, i_rd_waddr, i_wb_sel, i_funct3,
           i_addr_lo, i_alu_result, i_pc_plus4, i_load_word,
    output o_rd_wen, o_rd_waddr, o_rd_wdata, o_retire, o_misaligned, o_retire_cnt
  );
endinterface

// File: rtl/wb_stage_load_extend.sv
// Combinational load-data extraction: picks byte/half/word from the aligned memory word,
// sign- or zero-extends, and flags misaligned halfword/word accesses.
module wb_stage_load_extend (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        misaligned
);
  import wb_stage_pkg::*;

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'(word >> {addr_lo, 3'b000});
    half_v = 16'(word >> {addr_lo[1], 4'b0000});
    data   = '0;
    case (funct3)
      LOAD_F3_LB:  data = {{24{byte_v[7]}}, byte_v};
      LOAD_F3_LH:  data = {{16{half_v[15]}}, half_v};
      LOAD_F3_LW:  data = word;
      LOAD_F3_LBU: data = {24'd0, byte_v};
      LOAD_F3_LHU: data = {16'd0, half_v};
      default:     data = '0;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    if ((funct3 == LOAD_F3_LH || funct3 == LOAD_F3_LHU) && addr_lo[0])
      misaligned = 1'b1;
    else if (funct3 == LOAD_F3_LW && addr_lo != 2'b00)
      misaligned = 1'b1;
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback datapath feeding the register-file write port.
// All outputs come from registered state only, one cycle after capture.
module wb_stage #(
  parameter int RETIRE_CNT_W = 32
) (
  input logic       i_clk,
  input logic       i_rst,
  wb_stage_if.slave bus
);
  import wb_stage_pkg::*;

  mem_wb_t                 r_q;
  logic                    stall_q;
  logic [RETIRE_CNT_W-1:0] cnt_q;
  logic [31:0]             load_data;
  logic                    load_mis;
  logic                    is_load;
  logic                    misaligned;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q     <= '0;
      stall_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      stall_q <= bus.i_stall;
      if (bus.i_flush) begin
        r_q.valid  <= 1'b0;
        r_q.rd_wen <= 1'b0;
      end else if (!bus.i_stall) begin
        r_q.valid      <= bus.i_valid;
        r_q.rd_wen     <= bus.i_rd_wen;
        r_q.waddr      <= bus.i_rd_waddr;
        r_q.wb_sel     <= bus.i_wb_sel;
        r_q.funct3     <= bus.i_funct3;
        r_q.addr_lo    <= bus.i_addr_lo;
        r_q.alu_result <= bus.i_alu_result;
        r_q.pc_plus4   <= bus.i_pc_plus4;
        r_q.load_word  <= bus.i_load_word;
      end
      // Count at capture so the count already includes the instruction retiring this cycle.
      if (!bus.i_flush && !bus.i_stall && bus.i_valid)
        cnt_q <= cnt_q + RETIRE_CNT_W'(1);
    end
  end

  wb_stage_load_extend u_load_extend (
    .funct3     (r_q.funct3),
    .addr_lo    (r_q.addr_lo),
    .word       (r_q.load_word),
    .data       (load_data),
    .misaligned (load_mis)
  );

  assign is_load    = (r_q.wb_sel == WB_SEL_LOAD);
  assign misaligned = r_q.valid & is_load & load_mis;

  always_comb begin
    bus.o_rd_wdata = '0;
    case (r_q.wb_sel)
      WB_SEL_ALU:  bus.o_rd_wdata = r_q.alu_result;
      WB_SEL_LOAD: bus.o_rd_wdata = load_data;
      WB_SEL_PC4:  bus.o_rd_wdata = r_q.pc_plus4;
      default:     bus.o_rd_wdata = '0;
    endcase
  end

  assign bus.o_rd_wen     = r_q.valid & r_q.rd_wen & (r_q.waddr != 5'd0) & !misaligned;
  assign bus.o_rd_waddr   = r_q.waddr;
  assign bus.o_retire     = r_q.valid & !stall_q;
  assign bus.o_misaligned = misaligned;
  assign bus.o_retire_cnt = cnt_q;

endmodule
